// File: rtl/pc_stack_unit.sv
// Fetch-address generator: 13-bit PC, circular 8-entry call stack, redirect/flush to the ROM.
// Latency: a redirect strobe in cycle N sets pc_addr in N+1; pc_flush is combinational in cycle N.
// Backpressure: stall holds PC, pointer and stack and ignores ops; pc_rd_en drops while stalled.
// Optional build macro STACK_FLAGS_EN adds sticky overflow/underflow flags and stk_flag_clr.
module pc_stack_unit #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8,
  parameter int PTR_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  op_goto,
  input  logic                  op_call,
  input  logic                  op_return,
  input  logic                  op_skip,
  input  logic                  pcl_we,
  input  logic [7:0]            pcl_wdata,
  input  logic [10:0]           k_addr,
  input  logic [4:0]            pclath,
`ifdef STACK_FLAGS_EN
  input  logic                  stk_flag_clr,
  output logic                  stk_ovf,
  output logic                  stk_unf,
`endif
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_rd_en,
  output logic                  pc_flush,
  output logic [7:0]            pcl_rdata
);

  localparam logic [PTR_WIDTH-1:0]  PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_WIDTH-1:0]  ptr;
  logic [PTR_WIDTH-1:0]  ptr_dec;
  logic                  do_pop;
  logic                  do_push;

  // Decode the effective stack operation; return wins over a same-cycle call.
  always_comb begin
    ptr_dec = ptr - PTR_ONE;
    do_pop  = ~stall & op_return;
    do_push = ~stall & ~op_return & op_call;
  end

  // Next-PC selection and stack update in fixed priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_addr <= '0;
      ptr     <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (!stall) begin
      if (op_return) begin
        ptr     <= ptr_dec;
        pc_addr <= stack_mem[ptr_dec];
      end else if (op_goto) begin
        pc_addr <= {pclath[4:3], k_addr};
      end else if (op_call) begin
        stack_mem[ptr] <= pc_addr;
        ptr            <= ptr + PTR_ONE;
        pc_addr        <= {pclath[4:3], k_addr};
      end else if (pcl_we) begin
        pc_addr <= {pclath, pcl_wdata};
      end else begin
        // Taken skip and plain fetch both advance by one; wraps at 2^13.
        pc_addr <= pc_addr + ADDR_ONE;
      end
    end
  end

  // Any accepted redirect NOPs the word the ROM is fetching this cycle.
  always_comb begin
    pc_flush  = ~rst & ~stall & (op_return | op_goto | op_call | pcl_we | op_skip);
    pc_rd_en  = ~stall;
    pcl_rdata = pc_addr[7:0];
  end

`ifdef STACK_FLAGS_EN
  logic [PTR_WIDTH:0] occ;
  logic               stk_full;
  logic               stk_empty;

  // Occupancy only feeds the flags; pointer wrap is unaffected by it.
  always_comb begin
    stk_full  = (occ == (PTR_WIDTH+1)'(STACK_DEPTH));
    stk_empty = (occ == '0);
  end

  // Saturating occupancy count plus sticky flags; a set beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      if (do_push && !stk_full) begin
        occ <= occ + 1'b1;
      end else if (do_pop && !stk_empty) begin
        occ <= occ - 1'b1;
      end

      if (do_push && stk_full) begin
        stk_ovf <= 1'b1;
      end else if (stk_flag_clr) begin
        stk_ovf <= 1'b0;
      end

      if (do_pop && stk_empty) begin
        stk_unf <= 1'b1;
      end else if (stk_flag_clr) begin
        stk_unf <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: reset, PCL wrap, goto, call/return, stack wrap,
// stall/skip, op priority and mid-operation reset, with hand-computed expectations.
// Build with STACK_FLAGS_EN defined to also exercise the overflow/underflow flags.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        op_goto;
  logic        op_call;
  logic        op_return;
  logic        op_skip;
  logic        pcl_we;
  logic [7:0]  pcl_wdata;
  logic [10:0] k_addr;
  logic [4:0]  pclath;
  logic [12:0] pc_addr;
  logic        pc_rd_en;
  logic        pc_flush;
  logic [7:0]  pcl_rdata;
`ifdef STACK_FLAGS_EN
  logic        stk_flag_clr;
  logic        stk_ovf;
  logic        stk_unf;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .op_goto   (op_goto),
    .op_call   (op_call),
    .op_return (op_return),
    .op_skip   (op_skip),
    .pcl_we    (pcl_we),
    .pcl_wdata (pcl_wdata),
    .k_addr    (k_addr),
    .pclath    (pclath),
`ifdef STACK_FLAGS_EN
    .stk_flag_clr (stk_flag_clr),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf),
`endif
    .pc_addr   (pc_addr),
    .pc_rd_en  (pc_rd_en),
    .pc_flush  (pc_flush),
    .pcl_rdata (pcl_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ops();
    stall     = 1'b0;
    op_goto   = 1'b0;
    op_call   = 1'b0;
    op_return = 1'b0;
    op_skip   = 1'b0;
    pcl_we    = 1'b0;
    pcl_wdata = 8'h00;
    k_addr    = 11'h000;
  endtask

  task automatic test_reset();
    logic [12:0] exp_run [3];
    exp_run[0] = 13'h0001; exp_run[1] = 13'h0002; exp_run[2] = 13'h0003;
    idle_ops();
    pclath = 5'h00;
    rst = 1'b1;
    op_goto = 1'b1;
    k_addr = 11'h055;
    #1;
    vec_cnt++;
    if (pc_flush !== 1'b0) begin
      err_cnt++; $display("FAIL reset_flush: pc_flush=%b expected 0", pc_flush);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0000) begin
      err_cnt++; $display("FAIL reset_pc0: pc_addr=%h expected 0000", pc_addr);
    end
    op_goto = 1'b0;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0000) begin
      err_cnt++; $display("FAIL reset_pc1: pc_addr=%h expected 0000", pc_addr);
    end
`ifdef STACK_FLAGS_EN
    vec_cnt++;
    if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      err_cnt++; $display("FAIL reset_flags: ovf=%b unf=%b expected 0 0", stk_ovf, stk_unf);
    end
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (pc_flush !== 1'b0 || pc_rd_en !== 1'b1) begin
        err_cnt++; $display("FAIL reset_free_ctl%0d: flush=%b rd_en=%b expected 0 1", i, pc_flush, pc_rd_en);
      end
      cyc();
      vec_cnt++;
      if (pc_addr !== exp_run[i]) begin
        err_cnt++; $display("FAIL reset_free_pc%0d: pc_addr=%h expected %h", i, pc_addr, exp_run[i]);
      end
    end
  endtask

  task automatic test_pcl_wrap();
    pclath = 5'h1F;
    pcl_we = 1'b1;
    pcl_wdata = 8'hFF;
    #1;
    vec_cnt++;
    if (pc_flush !== 1'b1) begin
      err_cnt++; $display("FAIL pcl_flush: pc_flush=%b expected 1", pc_flush);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h1FFF || pcl_rdata !== 8'hFF) begin
      err_cnt++; $display("FAIL pcl_load: pc_addr=%h pcl_rdata=%h expected 1fff ff", pc_addr, pcl_rdata);
    end
    idle_ops();
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0000) begin
      err_cnt++; $display("FAIL pc_wrap: pc_addr=%h expected 0000", pc_addr);
    end
  endtask

  task automatic test_goto();
    pclath = 5'b11000;
    op_goto = 1'b1;
    k_addr = 11'h123;
    #1;
    vec_cnt++;
    if (pc_flush !== 1'b1) begin
      err_cnt++; $display("FAIL goto_flush: pc_flush=%b expected 1", pc_flush);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h1923) begin
      err_cnt++; $display("FAIL goto_target: pc_addr=%h expected 1923", pc_addr);
    end
    idle_ops();
  endtask

  task automatic test_call_return();
    logic [12:0] exp_seq [4];
    exp_seq[0] = 13'h0200; exp_seq[1] = 13'h0300; exp_seq[2] = 13'h0202; exp_seq[3] = 13'h0011;
    pclath = 5'h00;
    op_goto = 1'b1; k_addr = 11'h011;
    cyc();
    idle_ops();
    // CALL instruction at 0x010 executes while 0x011 is being fetched.
    op_call = 1'b1; k_addr = 11'h200;
    cyc();
    vec_cnt++;
    if (pc_addr !== exp_seq[0]) begin
      err_cnt++; $display("FAIL call1: pc_addr=%h expected %h", pc_addr, exp_seq[0]);
    end
    idle_ops();
    cyc();
    cyc();
    op_call = 1'b1; k_addr = 11'h300;
    cyc();
    vec_cnt++;
    if (pc_addr !== exp_seq[1]) begin
      err_cnt++; $display("FAIL call2: pc_addr=%h expected %h", pc_addr, exp_seq[1]);
    end
    idle_ops();
    op_return = 1'b1;
    cyc();
    vec_cnt++;
    if (pc_addr !== exp_seq[2]) begin
      err_cnt++; $display("FAIL ret1: pc_addr=%h expected %h", pc_addr, exp_seq[2]);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== exp_seq[3]) begin
      err_cnt++; $display("FAIL ret2: pc_addr=%h expected %h", pc_addr, exp_seq[3]);
    end
    idle_ops();
  endtask

  task automatic test_stack_wrap();
    logic [12:0] exp_pc;
    // Stack is empty, ptr=0, pc=0x011 on entry.
    for (int i = 1; i <= 9; i++) begin
      op_call = 1'b1;
      k_addr = 11'h400 + 11'(i);
      cyc();
      exp_pc = 13'h0400 + 13'(i);
      vec_cnt++;
      if (pc_addr !== exp_pc) begin
        err_cnt++; $display("FAIL wrap_call%0d: pc_addr=%h expected %h", i, pc_addr, exp_pc);
      end
`ifdef STACK_FLAGS_EN
      if (i >= 8) begin
        vec_cnt++;
        if (stk_ovf !== (i == 9)) begin
          err_cnt++; $display("FAIL wrap_ovf%0d: stk_ovf=%b expected %b", i, stk_ovf, (i == 9));
        end
      end
`endif
    end
    idle_ops();
    // Entry 0 now holds 0x408 (9th push); entries 1..7 hold 0x401..0x407.
    for (int j = 1; j <= 9; j++) begin
      op_return = 1'b1;
      cyc();
      exp_pc = (j == 1 || j == 9) ? 13'h0408 : 13'h0409 - 13'(j);
      vec_cnt++;
      if (pc_addr !== exp_pc) begin
        err_cnt++; $display("FAIL wrap_ret%0d: pc_addr=%h expected %h", j, pc_addr, exp_pc);
      end
`ifdef STACK_FLAGS_EN
      if (j >= 8) begin
        vec_cnt++;
        if (stk_unf !== (j == 9)) begin
          err_cnt++; $display("FAIL wrap_unf%0d: stk_unf=%b expected %b", j, stk_unf, (j == 9));
        end
      end
`endif
    end
    idle_ops();
`ifdef STACK_FLAGS_EN
    stk_flag_clr = 1'b1;
    cyc();
    stk_flag_clr = 1'b0;
    vec_cnt++;
    if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      err_cnt++; $display("FAIL flag_clr: ovf=%b unf=%b expected 0 0", stk_ovf, stk_unf);
    end
`endif
  endtask

  task automatic test_stall_skip();
    logic [12:0] held;
    held = pc_addr;
    stall = 1'b1;
    op_call = 1'b1;
    k_addr = 11'h7FF;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (pc_flush !== 1'b0 || pc_rd_en !== 1'b0) begin
        err_cnt++; $display("FAIL stall_ctl%0d: flush=%b rd_en=%b expected 0 0", i, pc_flush, pc_rd_en);
      end
      cyc();
      vec_cnt++;
      if (pc_addr !== held) begin
        err_cnt++; $display("FAIL stall_hold%0d: pc_addr=%h expected %h", i, pc_addr, held);
      end
    end
    idle_ops();
    op_goto = 1'b1; k_addr = 11'h040;
    cyc();
    idle_ops();
    op_skip = 1'b1;
    #1;
    vec_cnt++;
    if (pc_flush !== 1'b1) begin
      err_cnt++; $display("FAIL skip_flush: pc_flush=%b expected 1", pc_flush);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0041) begin
      err_cnt++; $display("FAIL skip_pc: pc_addr=%h expected 0041", pc_addr);
    end
    idle_ops();
    // An ignored push would have moved ptr to 1 and clobbered entry 0.
    op_return = 1'b1;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0407) begin
      err_cnt++; $display("FAIL stall_stack: pc_addr=%h expected 0407", pc_addr);
    end
    idle_ops();
  endtask

  task automatic test_midop_reset();
    op_goto = 1'b1; k_addr = 11'h055;
    cyc();
    idle_ops();
    rst = 1'b1;
    op_call = 1'b1; k_addr = 11'h123;
    #1;
    vec_cnt++;
    if (pc_flush !== 1'b0) begin
      err_cnt++; $display("FAIL midrst_flush: pc_flush=%b expected 0", pc_flush);
    end
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0000) begin
      err_cnt++; $display("FAIL midrst_pc: pc_addr=%h expected 0000", pc_addr);
    end
    rst = 1'b0;
    idle_ops();
  endtask

  task automatic test_priority();
    op_goto = 1'b1; k_addr = 11'h050;
    cyc();
    idle_ops();
    op_call = 1'b1; k_addr = 11'h060;
    cyc();
    idle_ops();
    // Return beats goto and call; the call push is dropped.
    op_return = 1'b1; op_call = 1'b1; op_goto = 1'b1; k_addr = 11'h0AA;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0050) begin
      err_cnt++; $display("FAIL prio_ret: pc_addr=%h expected 0050", pc_addr);
    end
    idle_ops();
    op_goto = 1'b1; pcl_we = 1'b1; k_addr = 11'h070; pcl_wdata = 8'h77;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0070) begin
      err_cnt++; $display("FAIL prio_goto: pc_addr=%h expected 0070", pc_addr);
    end
    idle_ops();
    pclath = 5'h02;
    pcl_we = 1'b1; op_skip = 1'b1; pcl_wdata = 8'h34;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0234 || pcl_rdata !== 8'h34) begin
      err_cnt++; $display("FAIL prio_pcl: pc_addr=%h pcl_rdata=%h expected 0234 34", pc_addr, pcl_rdata);
    end
    idle_ops();
    pclath = 5'h00;
    // ptr is back to 0 and the stack was cleared by reset: pop reads entry 7 = 0.
    op_return = 1'b1;
    cyc();
    vec_cnt++;
    if (pc_addr !== 13'h0000) begin
      err_cnt++; $display("FAIL prio_pop_empty: pc_addr=%h expected 0000", pc_addr);
    end
    idle_ops();
  endtask

  initial begin
    rst = 1'b1;
    pclath = 5'h00;
`ifdef STACK_FLAGS_EN
    stk_flag_clr = 1'b0;
`endif
    idle_ops();
    test_reset();
    test_pcl_wrap();
    test_goto();
    test_call_return();
    test_stack_wrap();
    test_stall_skip();
    test_midop_reset();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
